// File: rtl/pc_target_table_pkg.sv
// Shared types and default sizes for the writable multi-bank branch-target table.
package pc_target_table_pkg;

  localparam int unsigned DEF_D     = 12;
  localparam int unsigned DEF_A     = 5;
  localparam int unsigned DEF_BANKS = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  typedef logic [DEF_D-1:0] pc_t;

endpackage

// File: rtl/pc_target_table_bank.sv
// One program bank: per-entry target storage with valid bits, bulk invalidate,
// one write port and a combinational read port that returns 0 for unloaded slots.
module pc_target_bank #(
  parameter int unsigned D = 12,
  parameter int unsigned A = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [D-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [D-1:0] o_rdata,
  output logic         o_hit
);

  localparam int unsigned N = 2 ** A;

  logic [D-1:0] r_mem [N];
  logic [N-1:0] r_valid;

  // Target storage is deliberately left unreset; the valid bits gate every read.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_waddr] <= 1'b1;
    end
  end

  always_comb begin
    o_hit   = r_valid[i_raddr];
    o_rdata = o_hit ? r_mem[i_raddr] : '0;
  end

endmodule

// File: rtl/pc_target_table.sv
// Multi-bank branch-target table: streaming loader FSM plus combinational lookup
// muxed across banks by rd_bank.
module pc_target_table
  import pc_target_table_pkg::*;
#(
  parameter int unsigned D     = DEF_D,
  parameter int unsigned A     = DEF_A,
  parameter int unsigned BANKS = DEF_BANKS,
  localparam int unsigned BW   = $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] rd_bank,
  input  logic [A-1:0]  addr,
  output logic [D-1:0]  target,
  output logic          hit,
  input  logic          load_start,
  input  logic [BW-1:0] load_bank,
  input  logic [A-1:0]  load_base,
  input  logic [A:0]    load_len,
  input  logic          load_valid,
  input  logic [D-1:0]  load_data,
  output logic          load_ready,
  output logic          load_busy,
  output logic          load_done
);

  state_e        r_state;
  logic [BW-1:0] r_bank;
  logic [A-1:0]  r_ptr;
  logic [A:0]    r_rem;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic             w_acc;
  logic [BANKS-1:0] w_we;
  logic [BANKS-1:0] w_clr;
  logic [D-1:0]     w_rdata [BANKS];
  logic [BANKS-1:0] w_hit;

  assign w_acc = (r_state == LOAD) && load_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load_start) begin
            r_bank <= load_bank;
            r_ptr  <= load_base;
            r_rem  <= load_len;
            r_busy <= 1'b1;
            if (load_len != '0) begin
              r_state <= LOAD;
              r_ready <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            // Pointer wraps naturally at 2**A.
            r_ptr <= r_ptr + A'(1);
            r_rem <= r_rem - (A+1)'(1);
            if (r_rem == (A+1)'(1)) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_ready;
  assign load_busy  = r_busy;
  assign load_done  = r_done;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign w_we[b]  = w_acc && (r_bank == BW'(b));
    assign w_clr[b] = (r_state == IDLE) && load_start && (load_bank == BW'(b));

    pc_target_bank #(
      .D(D),
      .A(A)
    ) u_bank (
      .i_clk  (clk),
      .i_reset(reset),
      .i_clr  (w_clr[b]),
      .i_we   (w_we[b]),
      .i_waddr(r_ptr),
      .i_wdata(load_data),
      .i_raddr(addr),
      .o_rdata(w_rdata[b]),
      .o_hit  (w_hit[b])
    );
  end

  // Out-of-range rd_bank (non-power-of-two BANKS) reads as a miss.
  always_comb begin
    target = '0;
    hit    = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (rd_bank == BW'(b)) begin
        target = w_rdata[b];
        hit    = w_hit[b];
      end
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Scoreboard bench for pc_target_table: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_pc_target_table;
  import pc_target_table_pkg::*;

  localparam int K_TGT   = 0;
  localparam int K_HIT   = 1;
  localparam int K_DONE  = 2;
  localparam int K_BUSY  = 3;
  localparam int K_READY = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] rd_bank;
  logic [4:0] addr;
  pc_t        target;
  logic       hit;
  logic       load_start;
  logic [0:0] load_bank;
  logic [4:0] load_base;
  logic [5:0] load_len;
  logic       load_valid;
  pc_t        load_data;
  logic       load_ready;
  logic       load_busy;
  logic       load_done;

  chk_t sb[$];
  pc_t  wq[$];
  int   total = 0;
  int   bad   = 0;

  pc_target_table u_dut (
    .clk       (clk),
    .reset     (reset),
    .rd_bank   (rd_bank),
    .addr      (addr),
    .target    (target),
    .hit       (hit),
    .load_start(load_start),
    .load_bank (load_bank),
    .load_base (load_base),
    .load_len  (load_len),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .load_busy (load_busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_act(input int kind);
    case (kind)
      K_TGT:   return {20'd0, target};
      K_HIT:   return {31'd0, hit};
      K_DONE:  return {31'd0, load_done};
      K_BUSY:  return {31'd0, load_busy};
      default: return {31'd0, load_ready};
    endcase
  endfunction

  // Monitor: drain every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = sb.pop_front();
      act = get_act(c.kind);
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
      end
    end
  end

  task automatic push(input string name, input int kind, input int exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input int bank, input int a, input int t, input int h);
    rd_bank = bank[0:0];
    addr    = a[4:0];
    push({name, "_tgt"}, K_TGT, t);
    push({name, "_hit"}, K_HIT, h);
    tick();
  endtask

  // Full load sequence from wq, optionally with a stall cycle before each word.
  task automatic do_load(input string name, input int bank, input int base, input int len,
                         input bit gaps);
    load_start = 1'b1;
    load_bank  = bank[0:0];
    load_base  = base[4:0];
    load_len   = len[5:0];
    load_valid = 1'b0;
    push({name, "_idle_busy"}, K_BUSY, 0);
    push({name, "_idle_ready"}, K_READY, 0);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        load_valid = 1'b0;
        push({name, "_gap_ready"}, K_READY, 1);
        push({name, "_gap_done"}, K_DONE, 0);
        tick();
      end
      load_valid = 1'b1;
      load_data  = wq[i];
      push({name, "_word_ready"}, K_READY, 1);
      push({name, "_word_done"}, K_DONE, 0);
      push({name, "_word_busy"}, K_BUSY, 1);
      tick();
    end
    load_valid = 1'b0;
    push({name, "_done"}, K_DONE, 1);
    push({name, "_done_ready"}, K_READY, 0);
    push({name, "_done_busy"}, K_BUSY, 1);
    tick();
    push({name, "_after_done"}, K_DONE, 0);
    push({name, "_after_busy"}, K_BUSY, 0);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    rd_bank    = '0;
    addr       = '0;
    load_start = 1'b0;
    load_bank  = '0;
    load_base  = '0;
    load_len   = '0;
    load_valid = 1'b0;
    load_data  = '0;
    tick();
    tick();
    reset = 1'b0;

    push("rst_busy", K_BUSY, 0);
    push("rst_ready", K_READY, 0);
    push("rst_done", K_DONE, 0);
    look("rst_b0a0", 0, 0, 0, 0);
    look("rst_b1a0", 1, 0, 0, 0);

    // Basic load and lookup.
    wq = '{12'd10, 12'd16, 12'd45};
    do_load("basic", 0, 0, 3, 1'b0);
    look("basic_a0", 0, 0, 10, 1);
    look("basic_a1", 0, 1, 16, 1);
    look("basic_a2", 0, 2, 45, 1);
    look("basic_a3", 0, 3, 0, 0);

    // Wrap with stalls.
    wq = '{12'd1, 12'd2, 12'd3, 12'd4};
    do_load("wrap", 1, 30, 4, 1'b1);
    look("wrap_30", 1, 30, 1, 1);
    look("wrap_31", 1, 31, 2, 1);
    look("wrap_0", 1, 0, 3, 1);
    look("wrap_1", 1, 1, 4, 1);
    look("wrap_2", 1, 2, 0, 0);
    look("wrap_b0a0", 0, 0, 10, 1);

    // Bank independence and reload.
    wq = '{12'd99};
    do_load("b1", 1, 0, 1, 1'b0);
    wq = '{12'd7};
    do_load("b0re", 0, 5, 1, 1'b0);
    look("indep_b1a0", 1, 0, 99, 1);
    look("indep_b1a30", 1, 30, 0, 0);
    look("reload_a0", 0, 0, 0, 0);
    look("reload_a1", 0, 1, 0, 0);
    look("reload_a2", 0, 2, 0, 0);
    look("reload_a5", 0, 5, 7, 1);

    // len=0 invalidates bank1 without writes or ready.
    do_load("len0", 1, 0, 0, 1'b0);
    look("len0_b1a0", 1, 0, 0, 0);
    look("len0_b0a5", 0, 5, 7, 1);

    // Reset after 2 of 5 words.
    load_start = 1'b1;
    load_bank  = 1'b0;
    load_base  = 5'd0;
    load_len   = 6'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = pc_t'(50 + i);
      tick();
    end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    push("mid_busy", K_BUSY, 0);
    push("mid_ready", K_READY, 0);
    push("mid_done", K_DONE, 0);
    look("mid_b0a0", 0, 0, 0, 0);
    push("mid_done2", K_DONE, 0);
    look("mid_b0a5", 0, 5, 0, 0);
    look("mid_b1a0", 1, 0, 0, 0);
    wq = '{12'd5, 12'd6};
    do_load("post", 1, 10, 2, 1'b0);
    look("post_a10", 1, 10, 5, 1);
    look("post_a11", 1, 11, 6, 1);

    // load_valid in IDLE ignored.
    load_valid = 1'b1;
    load_data  = 12'd77;
    rd_bank    = 1'b1;
    addr       = 5'd12;
    push("idlev_busy", K_BUSY, 0);
    tick();
    load_valid = 1'b0;
    look("idlev_a12", 1, 12, 0, 0);
    look("idlev_a10", 1, 10, 5, 1);

    // load_start during LOAD ignored; same-cycle write shows old value.
    load_start = 1'b1;
    load_bank  = 1'b0;
    load_base  = 5'd20;
    load_len   = 6'd2;
    tick();
    load_bank  = 1'b1;
    load_base  = 5'd0;
    load_len   = 6'd5;
    load_valid = 1'b1;
    load_data  = 12'd200;
    rd_bank    = 1'b0;
    addr       = 5'd20;
    push("wr_old_tgt", K_TGT, 0);
    push("wr_old_hit", K_HIT, 0);
    tick();
    load_start = 1'b0;
    load_data  = 12'd201;
    push("wr_new_tgt", K_TGT, 200);
    push("wr_new_hit", K_HIT, 1);
    tick();
    load_valid = 1'b0;
    push("ign_done", K_DONE, 1);
    tick();
    look("ign_b0a21", 0, 21, 201, 1);
    look("ign_b1a10", 1, 10, 5, 1);
    look("ign_b0a5", 0, 5, 0, 0);

    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
